memory_stage_sram_controller: RTL

//   Consumer side of the EX/MEM stage register. Turns memoryReadEnabled/memoryWriteEnabled,

---
 rtl/memory_stage_sram_controller_pkg.sv | 23 ++
 rtl/memory_stage_sram_controller_if.sv | 33 +++
 rtl/memory_stage_sram_controller_sram_wait_counter.sv | 32 +++
 rtl/memory_stage_sram_controller.sv | 111 +++++++++++
 4 files changed

// File: rtl/memory_stage_sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// default SRAM base address and the byte-to-word address conversion.
package memory_stage_sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'd1024;
  localparam int unsigned WORD_SHIFT           = 2;
  localparam int unsigned DATA_WIDTH           = 32;

  // Byte address relative to base, converted to a word index (wraps mod 2^32).
  function automatic logic [31:0] word_address(input logic [31:0] byte_addr,
                                               input logic [31:0] base_addr);
    logic [31:0] w_offset;
    w_offset = byte_addr - base_addr;
    return w_offset >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/memory_stage_sram_controller_if.sv
// Bus between the pipeline/SRAM environment and the MEM-stage SRAM controller.
//   Pipeline side : memoryReadEnabled, memoryWriteEnabled, address, writeData -> ctrl
//                   stall, readData                                           <- ctrl
//   SRAM side     : sramReadData                                              -> ctrl
//                   sramAddress, sramWriteData, sramWriteEnableN              <- ctrl
// master = environment (pipeline + SRAM), slave = controller.
interface memory_stage_sram_controller_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  import memory_stage_sram_controller_pkg::*;

  logic                  memoryReadEnabled;
  logic                  memoryWriteEnabled;
  logic [DATA_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  stall;
  logic [DATA_WIDTH-1:0] readData;
  logic [ADDR_WIDTH-1:0] sramAddress;
  logic [DATA_WIDTH-1:0] sramWriteData;
  logic [DATA_WIDTH-1:0] sramReadData;
  logic                  sramWriteEnableN;

  modport master (
    output memoryReadEnabled, memoryWriteEnabled, address, writeData, sramReadData,
    input  stall, readData, sramAddress, sramWriteData, sramWriteEnableN
  );

  modport slave (
    input  memoryReadEnabled, memoryWriteEnabled, address, writeData, sramReadData,
    output stall, readData, sramAddress, sramWriteData, sramWriteEnableN
  );

endinterface

// File: rtl/memory_stage_sram_controller_sram_wait_counter.sv
// Wait-state counter for fixed-latency SRAM accesses.
// Counts while enabled, wraps to 0 after the terminal count WAIT_CYCLES-1.
//   clk, rst       : clock, synchronous active-high reset
//   i_clear        : synchronous clear (priority over enable)
//   i_enable       : count enable
//   o_terminal_c   : combinational flag, count == WAIT_CYCLES-1
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal_c
);

  localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

  logic [CNT_W-1:0] r_count;

  // Up-counter; wrapping at terminal keeps it reusable for back-to-back bursts.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_terminal_c ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_terminal_c = (r_count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/memory_stage_sram_controller.sv
// MEM-stage SRAM controller: converts load/store requests from the EX/MEM
// register into a WAIT_CYCLES-long access on a 32-bit SRAM, freezing the
// pipeline with stall until the access completes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of memory_stage_sram_controller_if
//              (requests/stall/readData toward the pipeline, SRAM pins)
module memory_stage_sram_controller
  import memory_stage_sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 4,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input logic                            clk,
  input logic                            rst,
  memory_stage_sram_controller_if.slave  bus
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_finish;
  logic                  w_terminal;
  logic                  w_stall;

  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [DATA_WIDTH-1:0] r_sram_wdata;
  logic                  r_is_write;
  logic                  r_we_n;
  logic [DATA_WIDTH-1:0] r_read_data;

  assign w_req = bus.memoryReadEnabled | bus.memoryWriteEnabled;

  // Wait-state counter runs only in ACCESS and sits at zero otherwise.
  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (r_state != ACCESS),
    .i_enable     (r_state == ACCESS),
    .o_terminal_c (w_terminal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode. DONE ignores the still-held request.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_stall      = 1'b1;
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        w_stall = 1'b1;
        if (w_terminal) begin
          w_finish     = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output/datapath registers: latched on accept, write strobe spans ACCESS only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_is_write   <= 1'b0;
      r_we_n       <= 1'b1;
      r_read_data  <= '0;
    end else begin
      if (w_accept) begin
        r_sram_addr  <= ADDR_WIDTH'(word_address(bus.address, BASE_ADDRESS));
        r_sram_wdata <= bus.writeData;
        r_is_write   <= bus.memoryWriteEnabled;
        r_we_n       <= ~bus.memoryWriteEnabled;
      end
      if (w_finish) begin
        r_we_n <= 1'b1;
        if (!r_is_write) begin
          r_read_data <= bus.sramReadData;
        end
      end
    end
  end

  assign bus.stall            = w_stall;
  assign bus.readData         = r_read_data;
  assign bus.sramAddress      = r_sram_addr;
  assign bus.sramWriteData    = r_sram_wdata;
  assign bus.sramWriteEnableN = r_we_n;

endmodule
